// File: rtl/instr_fetch.sv
// instr_fetch -- fetch stage ahead of the instruction decoder.
//
// Keeps the 12-bit fetch address and issues in-order reads to instruction
// memory over a valid/ready request bus. Responses come back on a valid-only
// bus in request order. Returned words go into a small show-ahead buffer and
// are handed to the decoder as {instr, instr_pc} with valid/ready. A redirect
// from execute flushes the buffer and marks every in-flight response for
// discard.
//
// Ports
//   clock, rst_l                 clock (rising edge), async active-low reset
//   imem_req_valid/ready, addr   read request channel
//   imem_rsp_valid, rsp_data     read response channel (in order, >=1 cycle)
//   instr_valid/ready, instr,    buffer head towards the decoder
//   instr_pc
//   redirect_valid, redirect_pc  restart fetch at redirect_pc
//   halt                         level: suppress new requests
//   err                          sticky: response with nothing outstanding
//
// No FSM: RUN / STALL / FLUSH are implied by the buffer, outstanding and
// drop counters.
module instr_fetch #(
   parameter logic [11:0] RESET_PC = 12'o4000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clock,
   input  logic        rst_l,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [11:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [14:0] imem_rsp_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [14:0] instr,
   output logic [11:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [11:0] redirect_pc,
   input  logic        halt,
   output logic        err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [CW-1:0] out_cnt_q,  out_cnt_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [11:0]   fetch_pc_q, fetch_pc_d;
   logic [11:0]   rsp_pc_q,   rsp_pc_d;
   logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [14:0]   data_q [DEPTH];
   logic [11:0]   pc_q   [DEPTH];
   logic          err_q;
   logic          started_q;

   logic          pop_req;
   logic          pop;
   logic          push;
   logic          accept;
   logic          rsp_ok;
   logic          rsp_drop;
   logic          stray;
   logic [CW:0]   occ;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Head of the buffer straight from registered storage.
   assign instr_valid = (fifo_cnt_q != '0);
   assign instr       = data_q[rd_ptr_q];
   assign instr_pc    = pc_q[rd_ptr_q];
   assign err         = err_q;
   assign imem_addr   = fetch_pc_q;

   always_comb begin
      pop_req  = instr_valid & instr_ready;
      // Credit: buffered + in flight (minus this cycle's pop) must leave room,
      // so a returning response always finds a free buffer slot.
      occ      = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q} - (CW + 1)'(pop_req);
      imem_req_valid = started_q & ~halt & ~redirect_valid &
                       (occ < (CW + 1)'(DEPTH));
      accept   = imem_req_valid & imem_req_ready;
      rsp_ok   = imem_rsp_valid & (out_cnt_q != '0);
      stray    = imem_rsp_valid & (out_cnt_q == '0);
      rsp_drop = rsp_ok & (drop_cnt_q != '0);
      pop      = pop_req & ~redirect_valid;
      push     = rsp_ok & (drop_cnt_q == '0) & ~redirect_valid;

      out_cnt_d  = out_cnt_q + CW'(accept) - CW'(rsp_ok);
      fetch_pc_d = accept ? fetch_pc_q + 12'd1 : fetch_pc_q;
      rsp_pc_d   = push   ? rsp_pc_q + 12'd1   : rsp_pc_q;
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
      fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      if (redirect_valid) begin
         // Everything still outstanding after this edge belongs to the old
         // stream, so the drop count becomes the post-edge outstanding count.
         drop_cnt_d = out_cnt_d;
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         fifo_cnt_d = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
      end
   end

   always_ff @(posedge clock or negedge rst_l) begin
      if (!rst_l) begin
         fifo_cnt_q <= '0;
         out_cnt_q  <= '0;
         drop_cnt_q <= '0;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         err_q      <= 1'b0;
         started_q  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
         out_cnt_q  <= out_cnt_d;
         drop_cnt_q <= drop_cnt_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         started_q  <= 1'b1;
         if (stray) err_q <= 1'b1;
         if (push) begin
            data_q[wr_ptr_q] <= imem_rsp_data;
            pc_q[wr_ptr_q]   <= rsp_pc_q;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clock;
   logic        rst_l;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [11:0] imem_addr;
   logic        imem_rsp_valid;
   logic [14:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [14:0] instr;
   logic [11:0] instr_pc;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   logic        halt;
   logic        err;

   instr_fetch #(.RESET_PC(12'o4000), .DEPTH(2)) dut (
      .clock(clock), .rst_l(rst_l),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .instr_pc(instr_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt(halt), .err(err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int errors = 0;
   int checks = 0;

   function automatic logic [14:0] memf(input logic [11:0] a);
      return {a[2:0] ^ 3'b101, a ^ 12'o5252};
   endfunction

   // Memory model: in-order responses, lat cycles after accept.
   typedef struct { logic [11:0] a; int unsigned due; } req_t;
   req_t        mq[$];
   int unsigned mcyc = 0;
   int unsigned lat  = 1;
   bit          inject = 1'b0;
   bit          acc_m;
   logic [11:0] a_m;

   initial begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(negedge clock);
         acc_m = imem_req_valid & imem_req_ready;
         a_m   = imem_addr;
         @(posedge clock);
         #2;
         mcyc++;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
         if (!rst_l) mq.delete();
         else begin
            if (acc_m) mq.push_back('{a_m, mcyc + lat - 1});
            if (inject) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = 15'h7fff;
            end else if (mq.size() > 0 && mq[0].due <= mcyc) begin
               imem_rsp_valid = 1'b1;
               imem_rsp_data  = memf(mq[0].a);
               void'(mq.pop_front());
            end
         end
      end
   end

   logic [11:0] acc_addr[$];
   logic [11:0] got_pc[$];
   logic [14:0] got_in[$];
   int          ncyc;
   int          first_acc;
   int          first_val;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      acc_addr.delete();
      got_pc.delete();
      got_in.delete();
      ncyc = 0;
      first_acc = -1;
      first_val = -1;
   endtask

   // One clock: sample at negedge, return 1 time unit after the next posedge.
   task automatic cyc();
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
         acc_addr.push_back(imem_addr);
         if (first_acc < 0) first_acc = ncyc;
      end
      if (instr_valid && first_val < 0) first_val = ncyc;
      if (instr_valid && instr_ready && !redirect_valid) begin
         got_pc.push_back(instr_pc);
         got_in.push_back(instr);
      end
      if (mq.size() > 2) chk("inflight", 32'(mq.size()), 32'd2);
      ncyc++;
      @(posedge clock);
      #1;
   endtask

   initial begin
      rst_l = 1'b0;
      imem_req_ready = 1'b1;
      instr_ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt = 1'b0;
      clr();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      chk("rst_instr_pc", 32'(instr_pc), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_l = 1'b1;

      // T1: zero-wait streaming from reset
      repeat (14) cyc();
      chk("t1_first_addr", 32'(acc_addr[0]), 32'o4000);
      chk("t1_latency", 32'(first_val - first_acc), 32'd2);
      chk("t1_rate", 32'(got_pc.size()), 32'(ncyc - first_val));
      for (int i = 0; i < acc_addr.size(); i++)
         chk("t1_addr", 32'(acc_addr[i]), 32'(12'(12'o4000 + i)));
      for (int i = 0; i < got_pc.size(); i++) begin
         chk("t1_pc", 32'(got_pc[i]), 32'(12'(12'o4000 + i)));
         chk("t1_instr", 32'(got_in[i]), 32'(memf(12'(12'o4000 + i))));
      end

      // T2: decoder stalls right after a redirect to 0100
      redirect_valid = 1'b1; redirect_pc = 12'o0100; instr_ready = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      clr();
      repeat (10) cyc();
      chk("t2_accepts", 32'(acc_addr.size()), 32'd2);
      chk("t2_addr0", 32'(acc_addr[0]), 32'o0100);
      chk("t2_addr1", 32'(acc_addr[1]), 32'o0101);
      chk("t2_req_off", 32'(imem_req_valid), 32'd0);
      chk("t2_head_valid", 32'(instr_valid), 32'd1);
      chk("t2_head_pc", 32'(instr_pc), 32'o0100);
      instr_ready = 1'b1;
      repeat (8) cyc();
      chk("t2_count", 32'(got_pc.size() >= 6), 32'd1);
      for (int i = 0; i < got_pc.size(); i++) begin
         chk("t2_pc", 32'(got_pc[i]), 32'(12'(12'o0100 + i)));
         chk("t2_instr", 32'(got_in[i]), 32'(memf(12'(12'o0100 + i))));
      end

      // T3: 3-cycle memory, redirect with two responses in flight
      halt = 1'b1;
      repeat (5) cyc();
      lat = 3; halt = 1'b0;
      clr();
      for (int i = 0; i < 10 && acc_addr.size() < 2; i++) cyc();
      chk("t3_inflight", 32'(acc_addr.size()), 32'd2);
      redirect_valid = 1'b1; redirect_pc = 12'o2100;
      cyc();
      redirect_valid = 1'b0;
      chk("t3_no_issue", 32'(acc_addr.size()), 32'd2);
      for (int i = 0; i < 30 && got_pc.size() < 3; i++) cyc();
      chk("t3_wait", 32'(got_pc.size() >= 3), 32'd1);
      chk("t3_new_addr", 32'(acc_addr[2]), 32'o2100);
      for (int i = 0; i < 3; i++) begin
         chk("t3_pc", 32'(got_pc[i]), 32'(12'(12'o2100 + i)));
         chk("t3_instr", 32'(got_in[i]), 32'(memf(12'(12'o2100 + i))));
      end

      // T4: address wrap 07777 -> 00000
      lat = 1;
      redirect_valid = 1'b1; redirect_pc = 12'o7776;
      clr();
      cyc();
      redirect_valid = 1'b0;
      for (int i = 0; i < 20 && got_pc.size() < 4; i++) cyc();
      chk("t4_wait", 32'(got_pc.size() >= 4), 32'd1);
      chk("t4_pc0", 32'(got_pc[0]), 32'o7776);
      chk("t4_pc1", 32'(got_pc[1]), 32'o7777);
      chk("t4_pc2", 32'(got_pc[2]), 32'o0000);
      chk("t4_pc3", 32'(got_pc[3]), 32'o0001);
      chk("t4_instr2", 32'(got_in[2]), 32'(memf(12'o0000)));

      // T5: halt with two outstanding
      halt = 1'b1;
      repeat (6) cyc();
      lat = 3; halt = 1'b0;
      clr();
      for (int i = 0; i < 10 && acc_addr.size() < 2; i++) cyc();
      halt = 1'b1;
      repeat (8) cyc();
      chk("t5_accepts", 32'(acc_addr.size()), 32'd2);
      chk("t5_seq", 32'(acc_addr[1]), 32'(12'(acc_addr[0] + 12'd1)));
      chk("t5_delivered", 32'(got_pc.size()), 32'd2);
      chk("t5_pc0", 32'(got_pc[0]), 32'(acc_addr[0]));
      chk("t5_pc1", 32'(got_pc[1]), 32'(acc_addr[1]));
      chk("t5_instr1", 32'(got_in[1]), 32'(memf(acc_addr[1])));
      halt = 1'b0;
      for (int i = 0; i < 10 && acc_addr.size() < 3; i++) cyc();
      chk("t5_resume", 32'(acc_addr[2]), 32'(12'(acc_addr[1] + 12'd1)));

      // T6: stray response, then async reset mid-burst
      halt = 1'b1;
      repeat (8) cyc();
      chk("t6_drained", 32'(instr_valid), 32'd0);
      inject = 1'b1;
      cyc();
      inject = 1'b0;
      cyc();
      chk("t6_err_set", 32'(err), 32'd1);
      chk("t6_ignored", 32'(instr_valid), 32'd0);
      repeat (3) cyc();
      chk("t6_err_hold", 32'(err), 32'd1);
      lat = 1; halt = 1'b0;
      repeat (5) cyc();
      chk("t6_burst_valid", 32'(instr_valid), 32'd1);
      chk("t6_burst_req", 32'(imem_req_valid), 32'd1);
      #2;
      rst_l = 1'b0;
      #1;
      chk("t6_async_valid", 32'(instr_valid), 32'd0);
      chk("t6_async_req", 32'(imem_req_valid), 32'd0);
      chk("t6_async_err", 32'(err), 32'd0);
      chk("t6_async_pc", 32'(instr_pc), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      rst_l = 1'b1;
      clr();
      repeat (6) cyc();
      chk("t6_restart_addr", 32'(acc_addr[0]), 32'o4000);
      chk("t6_restart_pc", 32'(got_pc[0]), 32'o4000);
      chk("t6_restart_lat", 32'(first_val - first_acc), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
